// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time,
// answers after a fixed latency, and raises a stall while the access is pending.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_stall
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          enterResp;
  logic          curWe;
  logic [31:0]   curAddr;
  logic [31:0]   curWdata;
  logic [2:0]    curFunct3;
  logic          accessErr;
  logic [AW-1:0] wordIdx;
  logic [31:0]   rdWord;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [31:0]   rdata_d;
  logic [3:0]    byteEn;
  logic [31:0]   wrData;
  logic          commit;

  assign accept     = req_valid && (state_q == IDLE);
  assign req_ready  = (state_q == IDLE);
  assign mem_stall  = ((state_q == IDLE) && req_valid) || (state_q == WAIT);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  // RESP is entered straight from an accept when LATENCY is 1, otherwise on the
  // WAIT edge where the count reaches zero, so RESP lands LATENCY cycles after accept.
  always_comb begin
    enterResp = 1'b0;
    if (state_q == IDLE) begin
      enterResp = accept && (LATENCY == 1);
    end else if (state_q == WAIT) begin
      enterResp = (cnt_q <= 4'd1);
    end
  end

  // In the single-cycle case the access completes on the accept edge, so the
  // live request fields are used instead of the not-yet-latched copies.
  always_comb begin
    if (state_q == IDLE) begin
      curWe     = req_we;
      curAddr   = req_addr;
      curWdata  = req_wdata;
      curFunct3 = req_funct3;
    end else begin
      curWe     = we_q;
      curAddr   = addr_q;
      curWdata  = wdata_q;
      curFunct3 = funct3_q;
    end
  end

  // Reject illegal sizes, misaligned halfwords/words, unsigned stores and out-of-range words.
  always_comb begin
    accessErr = 1'b0;
    case (curFunct3)
      3'b000:  accessErr = 1'b0;
      3'b001:  accessErr = curAddr[0];
      3'b010:  accessErr = |curAddr[1:0];
      3'b100:  accessErr = curWe;
      3'b101:  accessErr = curWe | curAddr[0];
      default: accessErr = 1'b1;
    endcase
    if ({2'b00, curAddr[31:2]} >= 32'(DEPTH_WORDS)) begin
      accessErr = 1'b1;
    end
  end

  assign wordIdx = curAddr[AW+1:2];
  assign rdWord  = mem[wordIdx];

  // Extract and extend the addressed byte/halfword; stores and errors answer with zero.
  always_comb begin
    case (curAddr[1:0])
      2'd0:    byteSel = rdWord[7:0];
      2'd1:    byteSel = rdWord[15:8];
      2'd2:    byteSel = rdWord[23:16];
      default: byteSel = rdWord[31:24];
    endcase
    halfSel = curAddr[1] ? rdWord[31:16] : rdWord[15:0];
    rdata_d = 32'd0;
    if (!accessErr && !curWe) begin
      case (curFunct3)
        3'b000:  rdata_d = {{24{byteSel[7]}}, byteSel};
        3'b001:  rdata_d = {{16{halfSel[15]}}, halfSel};
        3'b010:  rdata_d = rdWord;
        3'b100:  rdata_d = {24'd0, byteSel};
        3'b101:  rdata_d = {16'd0, halfSel};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // Replicate store data across lanes and enable only the lanes the access touches.
  always_comb begin
    byteEn = 4'b0000;
    wrData = curWdata;
    case (curFunct3)
      3'b000: begin
        byteEn = 4'b0001 << curAddr[1:0];
        wrData = {4{curWdata[7:0]}};
      end
      3'b001: begin
        byteEn = curAddr[1] ? 4'b1100 : 4'b0011;
        wrData = {2{curWdata[15:0]}};
      end
      3'b010:  byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  assign commit = rst_n && enterResp && curWe && !accessErr;

  // Byte-lane array write on the edge entering RESP; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  // Request FSM with latched access fields and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      funct3_q     <= 3'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      if (enterResp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= accessErr;
        resp_rdata_q <= rdata_d;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            cnt_q    <= 4'(LATENCY - 1);
            state_q  <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (enterResp) begin
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for the main
// load/store/error/reset/throughput cases and a LATENCY=1 instance for timing.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_stall;

  logic        l1Valid;
  logic        l1We;
  logic [31:0] l1Addr;
  logic [31:0] l1Wdata;
  logic [2:0]  l1Funct3;
  logic        l1Ready;
  logic        l1RespValid;
  logic [31:0] l1Rdata;
  logic        l1Err;
  logic        l1Stall;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_stall  (mem_stall)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dutL1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (l1Valid),
    .req_we     (l1We),
    .req_addr   (l1Addr),
    .req_wdata  (l1Wdata),
    .req_funct3 (l1Funct3),
    .req_ready  (l1Ready),
    .resp_valid (l1RespValid),
    .resp_rdata (l1Rdata),
    .resp_err   (l1Err),
    .mem_stall  (l1Stall)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full LATENCY=2 transaction: accept, WAIT, RESP, then the idle cycle after.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               input logic [31:0] expData, input logic expErr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    #1;
    checkOutput({tag, " ready@accept"}, 32'(req_ready), 32'd1);
    checkOutput({tag, " stall@accept"}, 32'(mem_stall), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checkOutput({tag, " valid@wait"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, " stall@wait"}, 32'(mem_stall), 32'd1);
    @(negedge clk);
    #1;
    checkOutput({tag, " valid@resp"}, 32'(resp_valid), 32'd1);
    checkOutput({tag, " err@resp"}, 32'(resp_err), 32'(expErr));
    checkOutput({tag, " rdata@resp"}, resp_rdata, expData);
    checkOutput({tag, " stall@resp"}, 32'(mem_stall), 32'd0);
    checkOutput({tag, " ready@resp"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, " valid@after"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, " ready@after"}, 32'(req_ready), 32'd1);
    checkOutput({tag, " rdata hold"}, resp_rdata, expData);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
    l1Valid = 1'b0; l1We = 1'b0; l1Addr = 32'd0; l1Wdata = 32'd0; l1Funct3 = 3'd0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset mem_stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;

    applyStimulus("SW 0x10", 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0);
    applyStimulus("LW 0x10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0);
    applyStimulus("SB 0x13", 1'b1, 32'h13, 32'h000000A5, 3'b000, 32'h0, 1'b0);
    applyStimulus("LW 0x10 b", 1'b0, 32'h10, 32'h0, 3'b010, 32'hA5ADBEEF, 1'b0);
    applyStimulus("LB 0x13", 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFA5, 1'b0);
    applyStimulus("LBU 0x13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h000000A5, 1'b0);
    applyStimulus("LH 0x12", 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFA5AD, 1'b0);

    applyStimulus("SW 0x14", 1'b1, 32'h14, 32'h11112222, 3'b010, 32'h0, 1'b0);
    applyStimulus("SH 0x16", 1'b1, 32'h16, 32'h00008001, 3'b001, 32'h0, 1'b0);
    applyStimulus("LW 0x14", 1'b0, 32'h14, 32'h0, 3'b010, 32'h80012222, 1'b0);
    applyStimulus("LHU 0x16", 1'b0, 32'h16, 32'h0, 3'b101, 32'h00008001, 1'b0);
    applyStimulus("LH 0x14", 1'b0, 32'h14, 32'h0, 3'b001, 32'h00002222, 1'b0);
    applyStimulus("LB 0x15", 1'b0, 32'h15, 32'h0, 3'b000, 32'h00000022, 1'b0);

    applyStimulus("err LHU 0x11", 1'b0, 32'h11, 32'h0, 3'b101, 32'h0, 1'b1);
    applyStimulus("err SW 0x12", 1'b1, 32'h12, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1);
    applyStimulus("err f3 011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
    applyStimulus("err SW 0x400", 1'b1, 32'h400, 32'h55555555, 3'b010, 32'h0, 1'b1);
    applyStimulus("err SBU 0x10", 1'b1, 32'h10, 32'h000000FF, 3'b100, 32'h0, 1'b1);
    applyStimulus("LW 0x10 after err", 1'b0, 32'h10, 32'h0, 3'b010, 32'hA5ADBEEF, 1'b0);

    // Reset during WAIT aborts the store to 0x20.
    applyStimulus("SW 0x20 pre", 1'b1, 32'h20, 32'h0BADF00D, 3'b010, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("abort resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("abort req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("abort resp_valid later", 32'(resp_valid), 32'd0);
    applyStimulus("LW 0x20 after abort", 1'b0, 32'h20, 32'h0, 3'b010, 32'h0BADF00D, 1'b0);

    // Back-to-back requests: accepts every third cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("stream ready c%0d", c), 32'(req_ready), 32'((c % 3) == 0));
      checkOutput($sformatf("stream stall c%0d", c), 32'(mem_stall), 32'((c % 3) != 2));
      checkOutput($sformatf("stream valid c%0d", c), 32'(resp_valid), 32'((c % 3) == 2));
      if ((c % 3) == 2) begin
        checkOutput($sformatf("stream rdata c%0d", c), resp_rdata, 32'hA5ADBEEF);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;

    // LATENCY=1 instance: store, then a back-to-back load stream.
    @(negedge clk);
    l1Valid = 1'b1; l1We = 1'b1; l1Addr = 32'h4; l1Wdata = 32'h11223344; l1Funct3 = 3'b010;
    #1;
    checkOutput("L1 SW ready", 32'(l1Ready), 32'd1);
    @(negedge clk);
    l1Valid = 1'b0;
    #1;
    checkOutput("L1 SW valid", 32'(l1RespValid), 32'd1);
    checkOutput("L1 SW err", 32'(l1Err), 32'd0);
    @(negedge clk);
    l1Valid = 1'b1; l1We = 1'b0; l1Addr = 32'h4; l1Funct3 = 3'b010;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checkOutput($sformatf("L1 ready c%0d", c), 32'(l1Ready), 32'((c % 2) == 0));
      checkOutput($sformatf("L1 stall c%0d", c), 32'(l1Stall), 32'((c % 2) == 0));
      checkOutput($sformatf("L1 valid c%0d", c), 32'(l1RespValid), 32'((c % 2) == 1));
      if ((c % 2) == 1) begin
        checkOutput($sformatf("L1 rdata c%0d", c), l1Rdata, 32'h11223344);
      end
    end
    @(negedge clk);
    l1Valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
